// File: rtl/fifo_ctrl_1r1w.sv
// Single-clock FIFO controller driving an external 1R1W memory: pointers, count, full/empty.
// Define FIFO_CTRL_BYPASS_EN for a same-cycle pass-through when the FIFO is empty.
module fifo_ctrl_1r1w #(
   parameter int p_num_entries = 8,
   parameter int p_bit_width   = 5,
   parameter int p_addr_width  = $clog2(p_num_entries),
   parameter int p_count_width = $clog2(p_num_entries + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     recv_val,
   output logic                     recv_rdy,
   input  logic [p_bit_width-1:0]   recv_msg,
   output logic                     send_val,
   input  logic                     send_rdy,
   output logic [p_bit_width-1:0]   send_msg,
   output logic                     mem_write_en,
   output logic [p_addr_width-1:0]  mem_write_addr,
   output logic [p_bit_width-1:0]   mem_write_data,
   output logic                     mem_read_en,
   output logic [p_addr_width-1:0]  mem_read_addr,
   input  logic [p_bit_width-1:0]   mem_read_data,
   output logic [p_count_width-1:0] count
);

   localparam logic [p_count_width-1:0] LP_FULL = p_count_width'(p_num_entries);
   localparam logic [p_addr_width-1:0]  LP_LAST = p_addr_width'(p_num_entries - 1);

   logic [p_addr_width-1:0]  r_wr_ptr;
   logic [p_addr_width-1:0]  r_rd_ptr;
   logic [p_count_width-1:0] r_count;
   logic                     w_full;
   logic                     w_empty;
   logic                     w_enq;
   logic                     w_deq;

   assign w_full  = (r_count == LP_FULL);
   assign w_empty = (r_count == '0);
   assign w_deq   = send_rdy & ~w_empty;

`ifdef FIFO_CTRL_BYPASS_EN
   logic w_bypass;
   // An empty FIFO hands the message straight through when downstream takes it.
   assign w_bypass = w_empty & recv_val & send_rdy;
   assign w_enq    = recv_val & ~w_full & ~w_bypass;
   assign send_val = ~w_empty | recv_val;
   assign send_msg = w_empty ? recv_msg : mem_read_data;
`else
   assign w_enq    = recv_val & ~w_full;
   assign send_val = ~w_empty;
   assign send_msg = mem_read_data;
`endif

   assign recv_rdy       = ~w_full;
   assign mem_write_en   = w_enq;
   assign mem_write_addr = r_wr_ptr;
   assign mem_write_data = recv_msg;
   assign mem_read_en    = ~w_empty;
   assign mem_read_addr  = r_rd_ptr;
   assign count          = r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         // Explicit wrap so non-power-of-two depths work.
         if (w_enq)
            r_wr_ptr <= (r_wr_ptr == LP_LAST) ? '0 : r_wr_ptr + p_addr_width'(1);
         if (w_deq)
            r_rd_ptr <= (r_rd_ptr == LP_LAST) ? '0 : r_rd_ptr + p_addr_width'(1);
         if (w_enq && !w_deq)
            r_count <= r_count + p_count_width'(1);
         else if (!w_enq && w_deq)
            r_count <= r_count - p_count_width'(1);
      end
   end

`ifndef SYNTHESIS
   a_count_max:    assert property (@(posedge clk) disable iff (reset) r_count <= LP_FULL);
   a_no_enq_full:  assert property (@(posedge clk) disable iff (reset) !(w_enq && w_full));
   a_no_deq_empty: assert property (@(posedge clk) disable iff (reset) !(w_deq && w_empty));
`endif

endmodule

// File: tb/tb_fifo_ctrl_1r1w.sv
// Bench for fifo_ctrl_1r1w: depth-8 vector table, reset/latency sequences, depth-5 wrap run.
// Expectations follow FIFO_CTRL_BYPASS_EN when it is defined.
module tb_fifo_ctrl_1r1w;

`ifdef FIFO_CTRL_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // depth-8 instance
   logic       recv_val, recv_rdy, send_val, send_rdy, wen, ren;
   logic [4:0] recv_msg, send_msg, wdata, rdata;
   logic [2:0] waddr, raddr;
   logic [3:0] count;
   logic [4:0] mem8 [8];

   fifo_ctrl_1r1w #(.p_num_entries(8), .p_bit_width(5)) u_dut (
      .clk(clk), .reset(reset),
      .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
      .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg),
      .mem_write_en(wen), .mem_write_addr(waddr), .mem_write_data(wdata),
      .mem_read_en(ren), .mem_read_addr(raddr), .mem_read_data(rdata),
      .count(count)
   );

   always @(posedge clk) if (!reset && wen) mem8[waddr] <= wdata;
   assign rdata = ren ? mem8[raddr] : 5'h00;

   // depth-5 instance for wrap-around
   logic       rv5, rrdy5, sval5, sr5, wen5, ren5;
   logic [4:0] msg5, smsg5, wdata5, rdata5;
   logic [2:0] waddr5, raddr5;
   logic [2:0] count5;
   logic [4:0] mem5 [8];

   fifo_ctrl_1r1w #(.p_num_entries(5), .p_bit_width(5)) u_dut5 (
      .clk(clk), .reset(reset),
      .recv_val(rv5), .recv_rdy(rrdy5), .recv_msg(msg5),
      .send_val(sval5), .send_rdy(sr5), .send_msg(smsg5),
      .mem_write_en(wen5), .mem_write_addr(waddr5), .mem_write_data(wdata5),
      .mem_read_en(ren5), .mem_read_addr(raddr5), .mem_read_data(rdata5),
      .count(count5)
   );

   always @(posedge clk) if (!reset && wen5) mem5[waddr5] <= wdata5;
   assign rdata5 = ren5 ? mem5[raddr5] : 5'h00;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       rv;
      logic [4:0] msg;
      logic       sr;
      logic       rrdy;
      logic       sval;
      logic [4:0] smsg;
      logic       wen;
      logic [3:0] cnt;
      logic [2:0] wa;
      logic [2:0] ra;
   } vec_t;

   vec_t vec[$];

   task automatic add(input logic rv, input logic [4:0] msg, input logic sr,
                      input logic rrdy, input logic sval, input logic [4:0] smsg,
                      input logic wen, input logic [3:0] cnt,
                      input logic [2:0] wa, input logic [2:0] ra);
      vec_t v;
      v.rv = rv; v.msg = msg; v.sr = sr; v.rrdy = rrdy; v.sval = sval;
      v.smsg = smsg; v.wen = wen; v.cnt = cnt; v.wa = wa; v.ra = ra;
      vec.push_back(v);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int   mcnt, mwp, mrp, sent, rcvd;
      logic byp, enq, deq;
      logic [4:0] q[$];

      recv_val = 0; recv_msg = 0; send_rdy = 0;
      rv5 = 0; msg5 = 0; sr5 = 0;

      // ---- vector table ----
      for (int k = 1; k <= 8; k++)
         add(1'b1, 5'(k), 1'b0, 1'b1, (k > 1) || BYP, ((k > 1) || BYP) ? 5'h01 : 5'h00,
             1'b1, 4'(k - 1), 3'(k - 1), 3'd0);
      add(1'b1, 5'h09, 1'b0, 1'b0, 1'b1, 5'h01, 1'b0, 4'd8, 3'd0, 3'd0);  // full, stalled
      add(1'b1, 5'h09, 1'b1, 1'b0, 1'b1, 5'h01, 1'b0, 4'd8, 3'd0, 3'd0);  // full, deq only
      add(1'b0, 5'h00, 1'b0, 1'b1, 1'b1, 5'h02, 1'b0, 4'd7, 3'd0, 3'd1);  // rdy back
      for (int k = 2; k <= 8; k++)
         add(1'b0, 5'h00, 1'b1, 1'b1, 1'b1, 5'(k), 1'b0, 4'(9 - k), 3'd0, 3'(k - 1));
      add(1'b0, 5'h00, 1'b1, 1'b1, 1'b0, 5'h00, 1'b0, 4'd0, 3'd0, 3'd0);  // drained
      for (int m = 0; m < 3; m++)
         add(1'b1, 5'(10 + m), 1'b0, 1'b1, (m > 0) || BYP, ((m > 0) || BYP) ? 5'h0A : 5'h00,
             1'b1, 4'(m), 3'(m), 3'd0);
      for (int i = 0; i < 10; i++)
         add(1'b1, 5'(13 + i), 1'b1, 1'b1, 1'b1, 5'(10 + i), 1'b1, 4'd3,
             3'((3 + i) % 8), 3'(i % 8));
      for (int j = 0; j < 3; j++)
         add(1'b0, 5'h00, 1'b1, 1'b1, 1'b1, 5'(20 + j), 1'b0, 4'(3 - j), 3'd5, 3'(2 + j));
      add(1'b0, 5'h00, 1'b0, 1'b1, 1'b0, 5'h00, 1'b0, 4'd0, 3'd5, 3'd5);

      // ---- reset state ----
      @(posedge clk); @(posedge clk); #1;
      #2;
      chk("rst.count", count, 0);
      chk("rst.recv_rdy", recv_rdy, 1);
      chk("rst.send_val", send_val, 0);
      chk("rst.send_msg", send_msg, 0);
      chk("rst.mem_write_en", wen, 0);
      chk("rst.mem_read_en", ren, 0);
      @(negedge clk); reset = 0;
      @(posedge clk); #1;

      // ---- table ----
      for (int i = 0; i < vec.size(); i++) begin
         recv_val = vec[i].rv; recv_msg = vec[i].msg; send_rdy = vec[i].sr;
         #2;
         chk($sformatf("vec%0d.recv_rdy", i), recv_rdy, vec[i].rrdy);
         chk($sformatf("vec%0d.send_val", i), send_val, vec[i].sval);
         chk($sformatf("vec%0d.send_msg", i), send_msg, vec[i].smsg);
         chk($sformatf("vec%0d.mem_write_en", i), wen, vec[i].wen);
         chk($sformatf("vec%0d.mem_write_data", i), wdata, vec[i].msg);
         chk($sformatf("vec%0d.count", i), count, vec[i].cnt);
         chk($sformatf("vec%0d.mem_read_en", i), ren, vec[i].cnt != 0);
         chk($sformatf("vec%0d.mem_write_addr", i), waddr, vec[i].wa);
         chk($sformatf("vec%0d.mem_read_addr", i), raddr, vec[i].ra);
         @(posedge clk); #1;
      end

      // ---- asynchronous reset mid-operation ----
      recv_val = 1; send_rdy = 0;
      recv_msg = 5'h11; @(posedge clk); #1;
      recv_msg = 5'h12; @(posedge clk); #1;
      recv_val = 0; recv_msg = 0;
      #2;
      chk("prerst.count", count, 2);
      #1 reset = 1;
      #1;
      chk("arst.count", count, 0);
      chk("arst.recv_rdy", recv_rdy, 1);
      chk("arst.send_val", send_val, 0);
      chk("arst.send_msg", send_msg, 0);
      chk("arst.mem_write_addr", waddr, 0);
      chk("arst.mem_read_addr", raddr, 0);
      @(negedge clk); reset = 0;
      @(posedge clk); #1;
      #2;
      chk("postrst.send_val", send_val, 0);
      @(posedge clk); #1;

      // ---- latency / bypass ----
      recv_val = 1; recv_msg = 5'h15; send_rdy = 1;
      #2;
      chk("lat0.send_val", send_val, BYP);
      chk("lat0.send_msg", send_msg, BYP ? 5'h15 : 5'h00);
      chk("lat0.mem_write_en", wen, !BYP);
      @(posedge clk); #1;
      recv_val = 0; recv_msg = 0;
      #2;
      chk("lat1.count", count, BYP ? 0 : 1);
      chk("lat1.send_val", send_val, !BYP);
      chk("lat1.send_msg", send_msg, BYP ? 5'h00 : 5'h15);
      @(posedge clk); #1;
      send_rdy = 0;
      #2;
      chk("lat2.count", count, 0);
      @(posedge clk); #1;

      // ---- depth-5 wrap-around with random stalls ----
      mcnt = 0; mwp = 0; mrp = 0; sent = 0; rcvd = 0;
      for (int cyc = 0; cyc < 300 && rcvd < 12; cyc++) begin
         rv5  = (sent < 12) && ($urandom_range(0, 3) != 0);
         msg5 = 5'(1 + sent);
         sr5  = ($urandom_range(0, 2) != 0);
         #2;
         byp = BYP && (mcnt == 0) && rv5 && sr5;
         enq = rv5 && (mcnt != 5) && !byp;
         deq = sr5 && (mcnt != 0);
         chk("w5.count", count5, mcnt);
         chk("w5.recv_rdy", rrdy5, mcnt != 5);
         chk("w5.mem_write_addr", waddr5, mwp);
         chk("w5.mem_read_addr", raddr5, mrp);
         chk("w5.send_val", sval5, (mcnt != 0) || (BYP && rv5));
         chk("w5.mem_write_en", wen5, enq);
         if (deq) begin
            chk("w5.send_msg", smsg5, q[0]);
            void'(q.pop_front());
            rcvd++;
            mrp = (mrp == 4) ? 0 : mrp + 1;
         end else if (byp) begin
            chk("w5.bypass_msg", smsg5, msg5);
            rcvd++;
         end
         if (enq) begin
            q.push_back(msg5);
            mwp = (mwp == 4) ? 0 : mwp + 1;
         end
         if (rv5 && mcnt != 5) sent++;
         mcnt = mcnt + (enq ? 1 : 0) - (deq ? 1 : 0);
         @(posedge clk); #1;
      end
      rv5 = 0; sr5 = 0;
      chk("w5.received", rcvd, 12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_ctrl_1r1w.md
Name: fifo_ctrl_1r1w

Overview:
Single-clock FIFO controller that sits directly upstream of the 1-read/1-write memory macro in the FIFO datapath. It accepts messages on a val/rdy receive interface and drives the memory's write and read ports. It returns the memory's read data on a val/rdy send interface. It owns the pointers, occupancy count and full/empty state; storage lives entirely in the attached memory.

Parameters:
- p_num_entries, 8, FIFO depth; must be >= 2; non-power-of-two allowed.
- p_bit_width, 5, message width in bits.
- p_addr_width, $clog2(p_num_entries), memory address width.
- p_count_width, $clog2(p_num_entries+1), occupancy count width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- recv_val  input  1  upstream message valid.
- recv_rdy  output  1  FIFO can accept a message.
- recv_msg  input  p_bit_width  upstream message.
- send_val  output  1  FIFO has a message for downstream.
- send_rdy  input  1  downstream accepts the message.
- send_msg  output  p_bit_width  message at the head of the FIFO.
- mem_write_en  output  1  memory write enable.
- mem_write_addr  output  p_addr_width  memory write address (tail pointer).
- mem_write_data  output  p_bit_width  memory write data; equals recv_msg.
- mem_read_en  output  1  memory read enable.
- mem_read_addr  output  p_addr_width  memory read address (head pointer).
- mem_read_data  input  p_bit_width  combinational memory read data.
- count  output  p_count_width  current occupancy.

Behaviour:
- Clock is clk; reset is asynchronous and active-high. While reset is high, state clears immediately, without waiting for a clock edge.
- State registers: wr_ptr, rd_ptr (p_addr_width bits) and count (p_count_width bits).
- Reset values: wr_ptr=0, rd_ptr=0, count=0. With count=0: recv_rdy=1, send_val=0, mem_write_en=0, mem_read_en=0, send_msg=0.
- full = (count == p_num_entries); empty = (count == 0).
- recv_rdy = !full. It does not depend on send_rdy, so there is no combinational rdy path through the FIFO when full.
- send_val = !empty.
- Fire conditions: enq = recv_val & recv_rdy; deq = send_val & send_rdy.
- Memory outputs:
  - mem_write_en = enq; mem_write_addr = wr_ptr; mem_write_data = recv_msg.
  - mem_read_en = !empty; mem_read_addr = rd_ptr.
  - send_msg = mem_read_data. This is zero when empty because the memory masks read data with read_en.
- Pointer updates:
  - On enq, wr_ptr advances by 1 and wraps from p_num_entries-1 to 0. Wrap uses explicit compare, never modulo 2^p_addr_width.
  - On deq, rd_ptr advances with the same wrap rule.
- Count update: enq only -> count+1; deq only -> count-1; both or neither -> unchanged.
- Latency: a message enqueued at cycle N is visible on send_msg with send_val=1 at cycle N+1 (memory write lands at posedge N+1).
- Boundary conditions:
  - Empty with recv_val=1: enq occurs; no deq is possible that cycle.
  - Full: recv_rdy=0 even if send_rdy=1. A deq in that cycle makes recv_rdy=1 in the next cycle.
  - Simultaneous enq and deq when 0 < count < p_num_entries: both pointers advance; count holds.
  - Reset asserted mid-operation: pointers and count clear immediately and all queued data is discarded. The memory suppresses writes while reset is high.
- Assertions (simulation only):
  - count never exceeds p_num_entries.
  - With bypass disabled, enq never occurs when full and deq never occurs when empty.

Optional Feature:
- Macro: FIFO_CTRL_BYPASS_EN.
- Defined, when empty:
  - send_val = recv_val and send_msg = recv_msg (combinational pass-through).
  - If recv_val & send_rdy: the message passes through, mem_write_en=0, and pointers and count are unchanged.
  - If recv_val & !send_rdy: the message is written to memory as normal.
  - When not empty, behaviour is identical to the base design.
- Undefined: no pass-through; minimum latency is 1 cycle as described above.

Test Plan:
- Reset then idle: assert reset asynchronously mid-cycle -> count=0, recv_rdy=1, send_val=0, send_msg=0 immediately.
- Fill and drain with depth 8, send_rdy=0: enqueue 0x01..0x08 -> recv_rdy=0 after the 8th enq, count=8. Then set send_rdy=1 -> send_msg sequence 0x01..0x08, after which send_val=0.
- Wrap-around with p_num_entries=5: 12 enq/deq interleaved with random stalls -> messages emerge in order with no loss; wr_ptr wraps 4->0.
- Simultaneous enq and deq at count=3: both fire for 10 cycles -> count stays 3 and ordering is preserved.
- Full with send_rdy=1: recv_val=1 and count=8 -> no enq that cycle; recv_rdy=1 next cycle and count=7.
- Bypass (macro defined): empty, recv_val=1, recv_msg=0x15, send_rdy=1 -> same cycle send_val=1, send_msg=0x15, mem_write_en=0, count stays 0. With the macro undefined, the same stimulus gives send_val=0 that cycle and send_msg=0x15 the next cycle.
